// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray/binary converter pipeline.
package gray_pkg;

  typedef enum logic {
    GRAY2BIN = 1'b0,
    BIN2GRAY = 1'b1
  } mode_e;

  // Bits resolved per stage of the Gray-to-binary prefix chain; the last stage takes the remainder.
  function automatic int seg_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/gray_seg_stage.sv
// One registered pipeline stage: resolves bits HI..LO of the Gray-to-binary chain
// (the first stage also does the whole binary-to-Gray conversion).
module gray_seg_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HI    = 15,
  parameter int LO    = 8,
  parameter bit FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  input  logic             carry_i,
  input  logic             err_i,
  input  logic             down_load_i,
  output logic             load_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output mode_e            mode_o,
  output logic             carry_o,
  output logic             err_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  mode_e            mode_q;
  logic             carry_q, carry_d;
  logic             err_q;

  assign load_o = !valid_q || down_load_i;

  // carry_d walks MSB-first through this segment; an empty segment passes carry_i through.
  always_comb begin
    data_d  = data_i;
    carry_d = carry_i;
    if (mode_i == GRAY2BIN) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          data_d[i] = carry_d ^ data_i[i];
          carry_d   = data_d[i];
        end
      end
    end else if (FIRST) begin
      data_d = data_i ^ (data_i >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= GRAY2BIN;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (load_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q  <= data_d;
        mode_q  <= mode_i;
        carry_q <= carry_d;
        err_q   <= err_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign carry_o = carry_q;
  assign err_o   = err_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with Gray adjacency checking and a saturating error counter.
// Handshake: a word moves on any cycle where valid && ready; a held word keeps data/flags stable.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_step_err,
  input  logic             chk_clear,
  output logic [ERRW-1:0]  err_count
);

  localparam int SEGW = seg_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);
  localparam logic [ERRW-1:0]  CNT_ONE  = ERRW'(1);

  logic [STAGES:0]  vld, ld, cry, err;
  logic [WIDTH-1:0] dat [STAGES+1];
  mode_e            md  [STAGES+1];
  logic             unused_tail;

  logic             accept, far;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] hist_q, hist_d;
  logic             hist_vld_q, hist_vld_d;
  logic [ERRW-1:0]  cnt_q, cnt_d;

  assign accept = in_valid && in_ready;
  assign diff   = in_data ^ hist_q;
  // Clearing the lowest set bit leaves something only when two or more bits differ.
  assign far    = |(diff & (diff - DATA_ONE));

  assign vld[0] = in_valid;
  assign dat[0] = in_data;
  assign md[0]  = mode_e'(in_mode);
  assign cry[0] = 1'b0;
  assign err[0] = hist_vld_q && !chk_clear && (md[0] == GRAY2BIN) && far;
  assign ld[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI     = WIDTH - 1 - k * SEGW;
    localparam int LO_RAW = WIDTH - (k + 1) * SEGW;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

    gray_seg_stage #(
      .WIDTH (WIDTH),
      .HI    (HI),
      .LO    (LO),
      .FIRST (k == 0)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .valid_i     (vld[k]),
      .data_i      (dat[k]),
      .mode_i      (md[k]),
      .carry_i     (cry[k]),
      .err_i       (err[k]),
      .down_load_i (ld[k+1]),
      .load_o      (ld[k]),
      .valid_o     (vld[k+1]),
      .data_o      (dat[k+1]),
      .mode_o      (md[k+1]),
      .carry_o     (cry[k+1]),
      .err_o       (err[k+1])
    );
  end

  assign unused_tail = cry[STAGES] ^ logic'(md[STAGES]);

  // A clear coinciding with a mode-0 accept makes that word the new first word.
  always_comb begin
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q && !chk_clear;
    if (accept && md[0] == GRAY2BIN) begin
      hist_d     = in_data;
      hist_vld_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (chk_clear) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && out_step_err && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready     = ld[0];
  assign out_valid    = vld[STAGES];
  assign out_data     = dat[STAGES];
  assign out_step_err = err[STAGES];
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: directed vector table, multi-cycle corner sequences,
// random stall stream against a reference model.
module tb_gray_codec_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int ERRW   = 2;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, in_mode;
  logic             out_valid, out_ready, out_step_err, chk_clear;
  logic [WIDTH-1:0] in_data, out_data;
  logic [ERRW-1:0]  err_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   mon_e, held;
  logic             held_vld = 1'b0;
  logic [WIDTH-1:0] m_hist = '0;
  logic             m_hist_vld = 1'b0;

  typedef struct {
    logic             clr;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             err;
  } vec_t;

  vec_t vt [15];
  vec_t alt [4];

  always #5 clk = ~clk;

  gray_codec_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .ERRW   (ERRW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_step_err (out_step_err),
    .chk_clear    (chk_clear),
    .err_count    (err_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] ref_g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] ref_b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard: predicts each accepted word, checks each output handshake and stall stability.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_hist_vld = 1'b0;
      held_vld   = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_step_err, out_data}, held);
      end
      held_vld = out_valid && !out_ready;
      held     = {out_step_err, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL out_extra: got %0h expected no word", {out_step_err, out_data});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_word", {out_step_err, out_data}, mon_e);
        end
      end
      if (in_valid && in_ready) begin
        if (in_mode) mon_e = {1'b0, ref_b2g(in_data)};
        else mon_e = {(m_hist_vld && !chk_clear && ($countones(in_data ^ m_hist) >= 2)),
                      ref_g2b(in_data)};
        exp_q.push_back(mon_e);
      end
      if (chk_clear) m_hist_vld = 1'b0;
      if (in_valid && in_ready && !in_mode) begin
        m_hist     = in_data;
        m_hist_vld = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    chk_clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_clear();
    chk_clear = 1'b1;
    tick();
    chk_clear = 1'b0;
  endtask

  task automatic send_word(input logic mode, input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_mode = mode; in_data = d;
    tick();
  endtask

  // Single word into an empty pipe: absent after one cycle, present after two.
  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vt[i].clr) pulse_clear();
      send_word(vt[i].mode, vt[i].din);
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_lat", i), out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_data", i), out_data, vt[i].dout);
      check($sformatf("v%0d_err", i), out_step_err, vt[i].err);
      tick();
    end
  endtask

  initial begin
    int sent, cyc, waits;
    logic acc;
    logic [WIDTH-1:0] one_hot;

    vt[0]  = '{1'b0, 1'b0, 16'h8000, 16'hFFFF, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 16'h0003, 16'h0002, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 16'h0002, 16'h0003, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 16'hFFFF, 16'h8000, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 16'h1234, 16'h1B2E, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 16'hC000, 16'h8000, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 16'h00FF, 16'h00AA, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 16'h0180, 16'h0100, 1'b1};
    vt[10] = '{1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0};
    vt[11] = '{1'b0, 1'b0, 16'h0003, 16'h0002, 1'b0};
    vt[12] = '{1'b0, 1'b0, 16'h0003, 16'h0002, 1'b0};
    vt[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vt[14] = '{1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0};

    alt[0] = '{1'b0, 1'b0, 16'h8000, 16'hFFFF, 1'b0};
    alt[1] = '{1'b0, 1'b1, 16'h0002, 16'h0003, 1'b0};
    alt[2] = '{1'b0, 1'b0, 16'h0003, 16'h0002, 1'b1};
    alt[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h8000, 1'b0};

    do_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_step_err", out_step_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    run_vec(0, 9);
    check("cnt_after_table", err_count, 3);
    run_vec(10, 13);
    check("cnt_after_seq", err_count, 1);

    // Alternating modes back-to-back: one result per cycle.
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        in_valid = 1'b1; in_mode = alt[j].mode; in_data = alt[j].din;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j >= 2) begin
        check($sformatf("alt%0d_valid", j - 2), out_valid, 1);
        check($sformatf("alt%0d_data", j - 2), out_data, alt[j-2].dout);
        check($sformatf("alt%0d_err", j - 2), out_step_err, alt[j-2].err);
      end
      tick();
    end
    check("cnt_after_alt", err_count, 2);

    // Saturation: seed word then five distance-2 words.
    pulse_clear();
    send_word(1'b0, 16'h0000);
    for (int j = 0; j < 5; j++) send_word(1'b0, (j % 2 == 0) ? 16'h0003 : 16'h0000);
    in_valid = 1'b0;
    repeat (4) tick();
    check("cnt_saturated", err_count, 3);

    // Clear while a flagged word is being taken at the output.
    out_ready = 1'b0;
    send_word(1'b0, 16'h0000);
    in_valid = 1'b0;
    waits = 0;
    @(negedge clk);
    while (!out_valid && waits < 10) begin
      waits++;
      @(negedge clk);
    end
    check("stall_valid", out_valid, 1);
    check("stall_err_flag", out_step_err, 1);
    tick(); tick();
    out_ready = 1'b1; chk_clear = 1'b1;
    tick();
    chk_clear = 1'b0;
    @(negedge clk);
    check("clear_priority", err_count, 0);
    check("clear_drained", out_valid, 0);
    tick();

    // Random stream with random backpressure.
    sent = 0; cyc = 0; acc = 1'b0; one_hot = WIDTH'(1);
    while (sent < 1000 && cyc < 20000) begin
      if (in_valid && acc) sent++;
      if (!in_valid || acc) begin
        if (sent < 1000 && $urandom_range(0, 4) != 0) begin
          in_valid = 1'b1;
          in_mode  = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 2))
            0:       in_data = WIDTH'($urandom);
            1:       in_data = in_data ^ (one_hot << $urandom_range(0, WIDTH - 1));
            default: in_data = in_data;
          endcase
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
    end
    check("rand_sent", sent, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    waits = 0;
    while (exp_q.size() != 0 && waits < 20) begin
      tick();
      waits++;
    end
    check("rand_drained", exp_q.size(), 0);

    // Reset with two words in flight: both discarded, history forgotten.
    out_ready = 1'b0;
    send_word(1'b0, 16'h0FF0);
    send_word(1'b0, 16'h0FF1);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("inrst_out_valid", out_valid, 0);
    check("inrst_err_count", err_count, 0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("postrst_out_valid", out_valid, 0);
    check("postrst_out_data", out_data, 0);
    check("postrst_step_err", out_step_err, 0);
    check("postrst_in_ready", in_ready, 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      check($sformatf("postrst_quiet%0d", j), out_valid, 0);
    end
    tick();
    run_vec(14, 14);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits, legal range 2..64.
REQ-002 Parameter STAGES, default 2, number of pipeline stages, legal range 1..4, STAGES <= WIDTH.
REQ-003 Parameter ERRW, default 8, width of the error counter.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_data/in_mode are valid this cycle.
REQ-007 Port in_ready, output, 1 bit: block accepts input this cycle.
REQ-008 Port in_data, input, WIDTH bits: code word to convert.
REQ-009 Port in_mode, input, 1 bit: 0 = Gray-to-binary, 1 = binary-to-Gray; sampled with the word.
REQ-010 Port out_valid, output, 1 bit: out_data/out_step_err are valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts output this cycle.
REQ-012 Port out_data, output, WIDTH bits: converted word.
REQ-013 Port out_step_err, output, 1 bit: this word violated Gray adjacency.
REQ-014 Port chk_clear, input, 1 bit: forget the adjacency history and zero err_count.
REQ-015 Port err_count, output, ERRW bits: saturating count of flagged words.

Function
REQ-016 An input word SHALL be accepted on any cycle with in_valid && in_ready.
REQ-017 Gray-to-binary SHALL produce b[W-1]=g[W-1] and b[i]=b[i+1]^g[i] for i = W-2 down to 0.
REQ-018 Binary-to-Gray SHALL produce g[W-1]=b[W-1] and g[i]=b[i+1]^b[i].
REQ-019 The Gray-to-binary prefix chain SHALL be split MSB-first into STAGES segments of ceil(WIDTH/STAGES) bits, with the last segment holding the remainder; each stage resolves one segment and registers the running carry bit.
REQ-020 Latency from acceptance to out_valid SHALL be exactly STAGES cycles when out_ready is held high.
REQ-021 Stage k SHALL load when it is empty or stage k+1 loads; the last stage loads when it is empty or out_ready is high; in_ready equals the stage-0 load condition.
REQ-022 Throughput SHALL be one word per cycle with out_ready high; internal bubbles collapse.
REQ-023 While out_valid && !out_ready, out_data and out_step_err SHALL stay stable and no word SHALL be lost or duplicated.
REQ-024 Adjacency check applies to words accepted with in_mode=0 only: Hamming distance to the previous mode-0 accepted word of 0 or 1 is legal; distance >= 2 sets the word's step_err.
REQ-025 The first mode-0 word after reset or chk_clear SHALL have no predecessor and step_err=0.
REQ-026 Mode-1 words SHALL carry step_err=0 and SHALL NOT update the adjacency history.
REQ-027 err_count SHALL increment by 1 when a word with step_err=1 is accepted at the output (out_valid && out_ready), and SHALL saturate at 2^ERRW-1.
REQ-028 chk_clear SHALL take priority over a simultaneous increment: err_count becomes 0 next cycle and the next mode-0 accept has no predecessor; words already in flight keep their flags.
REQ-029 in_mode SHALL travel with its word; mixing modes on consecutive cycles is legal.

Reset
REQ-030 reset high SHALL clear all stage-valid bits, the history-valid flag, and err_count next cycle.
REQ-031 During and on the cycle after reset: out_valid=0, out_step_err=0, out_data=0, err_count=0, in_ready=1 on the first cycle after reset deasserts.
REQ-032 Reset mid-stream SHALL discard all in-flight words without emitting them.

Structure
REQ-033 Package gray_pkg SHALL hold the mode typedef (GRAY2BIN=0, BIN2GRAY=1) and the function computing segment width from WIDTH and STAGES.
REQ-034 One sub-module gray_seg_stage SHALL implement one registered pipeline stage (valid, data, mode, carry, step_err, load logic), instantiated STAGES times by generate.

Verification
REQ-035 WIDTH=16, STAGES=2, mode 0, in 0x8000 -> out 0xFFFF after 2 cycles; in 0x0003 -> 0x0002.
REQ-036 Mode 1, in 0x0002 -> out 0x0003; in 0xFFFF -> 0x8000; alternate modes back-to-back -> each result correct, one per cycle.
REQ-037 Mode-0 sequence 0x0001, 0x0003, 0x0003, 0x0000 -> step_err 0,0,0,1; err_count = 1.
REQ-038 out_ready toggled randomly for 1000 random words -> output stream equals reference model in order, held stable while stalled.
REQ-039 ERRW=2, five consecutive distance-2 words -> err_count saturates at 3; chk_clear with a flagged word at the output -> err_count = 0.
REQ-040 Reset asserted with 2 words in flight -> no output emitted; next word 0x0001 gives step_err=0.
